reg_read_stage: RTL and testbench
=================================

REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 SHALL take parameter DATA_W, default 32: operand and register width.
REQ-002 SHALL take parameter PHYS_REGS, default 64: physical register count.
REQ-003 SHALL take parameter IDX_W, default 6: register index width, with 2**IDX_W >= PHYS_REGS.
REQ-004 SHALL take parameter NWB, default 2: number of write-back ports.
REQ-005 SHALL take parameter PAYLOAD_W, default 137: width of the opaque pass-through issue payload.
REQ-006 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-007 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port FREEZE  input  1  hold the output stage.
REQ-009 SHALL have port FLUSH  input  1  kill the output-stage instruction.
REQ-010 SHALL have port in_valid  input  1  issue slot holds an instruction.
REQ-011 SHALL have ports in_src_a and in_src_b  input  IDX_W  source physical indices.
REQ-012 SHALL have port in_payload  input  PAYLOAD_W  issue payload.
REQ-013 SHALL have port wb_en  input  NWB  per-port write enable.
REQ-014 SHALL have port wb_idx  input  NWB*IDX_W  write index; port k occupies bits [k*IDX_W +: IDX_W].
REQ-015 SHALL have port wb_data  input  NWB*DATA_W  write data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-016 SHALL have port out_valid  output  1  output stage holds a live instruction.
REQ-017 SHALL have ports out_op_a and out_op_b  output  DATA_W  read operands.
REQ-018 SHALL have port out_payload  output  PAYLOAD_W  registered payload.

Function
REQ-019 SHALL write Reg[wb_idx k] <= wb_data k at each edge for every port k with wb_en[k]=1, independent of FREEZE and FLUSH.
REQ-020 SHALL, when several enabled ports target one index, let the highest-numbered port win.
REQ-021 SHALL ignore writes with index >= PHYS_REGS; reads of such indices SHALL return 0.
REQ-022 SHALL form each operand by same-cycle bypass: wb_data of the highest-numbered enabled port whose wb_idx equals the source index, otherwise Reg[src].
REQ-023 SHALL, when FREEZE=0, capture the bypassed operands, in_payload, in_src_a and in_src_b, and set out_valid <= in_valid, giving a latency of one cycle.
REQ-024 SHALL, when FREEZE=1, hold out_valid, out_payload and the captured source indices unchanged.
REQ-025 SHALL, while FREEZE=1, snoop write-backs: each held operand whose held source index matches an enabled write-back port SHALL be replaced by that port's data (highest port wins), so no stale operand leaves the stage.
REQ-026 SHALL give FLUSH priority over FREEZE: FLUSH=1 sets out_valid <= 0 at the edge; operand and payload contents are don't-care.
REQ-027 SHALL update operands, payload and write-backs when in_valid=0 and FREEZE=0; only out_valid marks liveness.

Reset
REQ-028 SHALL, while RESET=0, force out_valid, out_op_a, out_op_b, out_payload, the held source indices and every Reg entry to 0 asynchronously.
REQ-029 SHALL, on a reset asserted mid-FREEZE, discard the held instruction; out_valid SHALL be 0 on the first edge after release unless in_valid=1 and FREEZE=0.

Verification
REQ-030 Bench SHALL cover: wb port0 idx5=0xA5A5A5A5; next cycle in_valid, src_a=5 -> out_op_a=0xA5A5A5A5, out_valid=1 one edge later.
REQ-031 Bench SHALL cover: same cycle, wb port0 idx7=0x11, port1 idx7=0x22, src_b=7 -> out_op_b=0x22, and Reg[7]=0x22 afterward.
REQ-032 Bench SHALL cover: FREEZE=1 holding src_a=9 (op 0x0), wb idx9=0x33 during the freeze -> out_op_a=0x33 after the edge; after FREEZE drops, the next instruction is captured.
REQ-033 Bench SHALL cover: FREEZE=1 and FLUSH=1 together with out_valid=1 -> out_valid=0 after the edge.
REQ-034 Bench SHALL cover: with PHYS_REGS=48, wb idx50=0xFF, then read src_a=50 -> out_op_a=0, no entry modified.
REQ-035 Bench SHALL cover: RESET pulsed low mid-stream -> all outputs 0 immediately, all reads return 0 afterward.

Source files
------------

// File: rtl/reg_read_stage.sv
// reg_read_stage: physical register file with same-cycle write-back bypass
// feeding a one-entry output stage. Latency: one cycle from issue to outputs.
// Backpressure: FREEZE holds the stage (operands keep snooping write-backs);
// FLUSH kills it.
// Ports: CLK/RESET (async, active-low); FREEZE, FLUSH stage control;
//   in_valid/in_src_a/in_src_b/in_payload issue slot;
//   wb_en/wb_idx/wb_data packed NWB write-back ports;
//   out_valid/out_op_a/out_op_b/out_payload registered output stage.
module reg_read_stage #(
  parameter int DATA_W    = 32,
  parameter int PHYS_REGS = 64,
  parameter int IDX_W     = 6,
  parameter int NWB       = 2,
  parameter int PAYLOAD_W = 137
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FREEZE,
  input  logic                   FLUSH,
  input  logic                   in_valid,
  input  logic [IDX_W-1:0]       in_src_a,
  input  logic [IDX_W-1:0]       in_src_b,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic [NWB-1:0]         wb_en,
  input  logic [NWB*IDX_W-1:0]   wb_idx,
  input  logic [NWB*DATA_W-1:0]  wb_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_op_a,
  output logic [DATA_W-1:0]      out_op_b,
  output logic [PAYLOAD_W-1:0]   out_payload
);

  logic [DATA_W-1:0] regs [PHYS_REGS];
  logic [IDX_W-1:0]  held_src_a;
  logic [IDX_W-1:0]  held_src_b;

  // Indices beyond the implemented registers never match a write and read as 0.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < PHYS_REGS;
  endfunction

  // Operand read with bypass; ascending port scan lets the highest port win.
  function automatic logic [DATA_W-1:0] read_bypass(input logic [IDX_W-1:0] src);
    logic [DATA_W-1:0] val;
    val = '0;
    if (in_range(src)) begin
      val = regs[src];
      for (int k = 0; k < NWB; k++) begin
        if (wb_en[k] && wb_idx[k*IDX_W +: IDX_W] == src)
          val = wb_data[k*DATA_W +: DATA_W];
      end
    end
    return val;
  endfunction

  // Refresh a held operand from any write-back aimed at its source index.
  function automatic logic [DATA_W-1:0] snoop(input logic [IDX_W-1:0] src,
                                              input logic [DATA_W-1:0] cur);
    logic [DATA_W-1:0] val;
    val = cur;
    if (in_range(src)) begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_en[k] && wb_idx[k*IDX_W +: IDX_W] == src)
          val = wb_data[k*DATA_W +: DATA_W];
      end
    end
    return val;
  endfunction

  // Register file: later ports' non-blocking writes override earlier ones.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < PHYS_REGS; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NWB; k++) begin
        for (int i = 0; i < PHYS_REGS; i++) begin
          if (wb_en[k] && wb_idx[k*IDX_W +: IDX_W] == IDX_W'(i))
            regs[i] <= wb_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Output stage. Operands/payload update even for bubbles; out_valid alone
  // marks liveness. FLUSH overrides FREEZE for out_valid only.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_valid   <= 1'b0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_payload <= '0;
      held_src_a  <= '0;
      held_src_b  <= '0;
    end else begin
      if (FREEZE) begin
        out_op_a <= snoop(held_src_a, out_op_a);
        out_op_b <= snoop(held_src_b, out_op_b);
      end else begin
        out_op_a    <= read_bypass(in_src_a);
        out_op_b    <= read_bypass(in_src_b);
        out_payload <= in_payload;
        held_src_a  <= in_src_a;
        held_src_b  <= in_src_b;
      end
      if (FLUSH)       out_valid <= 1'b0;
      else if (!FREEZE) out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
module tb_reg_read_stage;
  localparam int DW  = 32;
  localparam int NR  = 48;
  localparam int IW  = 6;
  localparam int NW  = 2;
  localparam int PW  = 137;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            FREEZE, FLUSH, in_valid;
  logic [IW-1:0]   in_src_a, in_src_b;
  logic [PW-1:0]   in_payload;
  logic [NW-1:0]   wb_en;
  logic [NW*IW-1:0] wb_idx;
  logic [NW*DW-1:0] wb_data;
  logic            out_valid;
  logic [DW-1:0]   out_op_a, out_op_b;
  logic [PW-1:0]   out_payload;

  always #5 CLK = ~CLK;

  reg_read_stage #(.DATA_W(DW), .PHYS_REGS(NR), .IDX_W(IW), .NWB(NW), .PAYLOAD_W(PW)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH), .in_valid(in_valid),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_payload(in_payload),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_payload(out_payload)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [PW-1:0] p;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural register contents plus the held stage.
  logic [DW-1:0] mreg [NR];
  logic          mv;
  logic [DW-1:0] ma, mb;
  logic [IW-1:0] msa, msb;
  logic [PW-1:0] mp;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_payload();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  // Value a write-back port set delivers for index s, or the fallback.
  function automatic logic [DW-1:0] wb_hit(input logic [IW-1:0] s, input logic [DW-1:0] fallback);
    logic [DW-1:0] r;
    r = fallback;
    if (int'(s) < NR)
      for (int k = 0; k < NW; k++)
        if (wb_en[k] && wb_idx[k*IW +: IW] == s) r = wb_data[k*DW +: DW];
    return r;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [IW-1:0] s);
    if (int'(s) >= NR) return '0;
    return wb_hit(s, mreg[int'(s)]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mreg[i] = '0;
    mv = 1'b0; ma = '0; mb = '0; msa = '0; msb = '0; mp = '0;
  endtask

  task automatic drv(input logic v, input logic [IW-1:0] sa, input logic [IW-1:0] sb,
                     input logic fr, input logic fl, input logic [NW-1:0] en,
                     input logic [IW-1:0] i0, input logic [DW-1:0] d0,
                     input logic [IW-1:0] i1, input logic [DW-1:0] d1);
    in_valid = v; in_src_a = sa; in_src_b = sb; FREEZE = fr; FLUSH = fl;
    wb_en = en; wb_idx = {i1, i0}; wb_data = {d1, d0};
    in_payload = rnd_payload();
  endtask

  // One clock: predict the stage after the edge, then queue the expectation.
  task automatic step();
    logic          nv;
    logic [DW-1:0] na, nb;
    logic [IW-1:0] nsa, nsb;
    logic [PW-1:0] np;
    if (FREEZE) begin
      na = wb_hit(msa, ma); nb = wb_hit(msb, mb);
      nsa = msa; nsb = msb; np = mp;
    end else begin
      na = m_read(in_src_a); nb = m_read(in_src_b);
      nsa = in_src_a; nsb = in_src_b; np = in_payload;
    end
    nv = FLUSH ? 1'b0 : (FREEZE ? mv : in_valid);
    for (int k = 0; k < NW; k++)
      if (wb_en[k] && int'(wb_idx[k*IW +: IW]) < NR)
        mreg[int'(wb_idx[k*IW +: IW])] = wb_data[k*DW +: DW];
    @(posedge CLK);
    mv = nv; ma = na; mb = nb; msa = nsa; msb = nsb; mp = np;
    sb_q.push_back('{v: nv, a: na, b: nb, p: np});
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, '0);
    chk({tag, "_op_a"}, out_op_a, '0);
    chk({tag, "_op_b"}, out_op_b, '0);
    chk({tag, "_payload"}, out_payload, '0);
  endtask

  // Called at posedge+1; asserts reset between edges, after the monitor's sample.
  task automatic reset_pulse();
    #4;
    RESET = 1'b0;
    #1;
    chk_zero("rst_async");
    model_reset();
    @(posedge CLK);
    #3;
    chk_zero("rst_held");
    RESET = 1'b1;
  endtask

  function automatic logic [IW-1:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return IW'($urandom_range(0, 63));
    return IW'($urandom_range(0, 11));
  endfunction

  task automatic rnd_step();
    drv($urandom_range(0, 9) < 7, rnd_idx(), rnd_idx(), $urandom_range(0, 3) == 0,
        $urandom_range(0, 9) == 0, NW'($urandom_range(0, 3)),
        rnd_idx(), $urandom, rnd_idx(), $urandom);
    step();
  endtask

  // Monitor: compares each queued expectation against the DUT after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("out_valid", out_valid, e.v);
        if (e.v) begin
          chk("out_op_a", out_op_a, e.a);
          chk("out_op_b", out_op_b, e.b);
          chk("out_payload", out_payload, e.p);
        end
      end
    end
  end

  initial begin
    RESET = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk_zero("reset_state");
    #20;
    RESET = 1'b1;

    // Write then read through the register file.
    drv(0, 0, 0, 0, 0, 2'b01, 5, 32'hA5A5_A5A5, 0, 0); step();
    drv(1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
    // Same-index collision: port 1 wins for bypass and for the stored value.
    drv(1, 0, 7, 0, 0, 2'b11, 7, 32'h11, 7, 32'h22); step();
    drv(1, 7, 7, 0, 0, 2'b00, 0, 0, 0, 0); step();
    // Freeze with operand snoop, then release.
    drv(1, 9, 5, 0, 0, 2'b00, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 0, 2'b01, 9, 32'h33, 0, 0); step();
    drv(0, 0, 0, 1, 0, 2'b10, 0, 0, 5, 32'h44); step();
    drv(1, 5, 7, 0, 0, 2'b00, 0, 0, 0, 0); step();
    // Flush beats freeze.
    drv(0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0); step();
    // Out-of-range write is dropped, out-of-range read returns zero.
    drv(0, 0, 0, 0, 0, 2'b01, 50, 32'hFF, 0, 0); step();
    drv(1, 50, 5, 0, 0, 2'b00, 0, 0, 0, 0); step();
    drv(1, 9, 7, 0, 0, 2'b00, 0, 0, 0, 0); step();

    for (int i = 0; i < 200; i++) rnd_step();

    // Reset while frozen on a live instruction.
    drv(1, 3, 4, 0, 0, 2'b00, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0); step();
    reset_pulse();
    drv(1, 5, 7, 1, 0, 2'b00, 0, 0, 0, 0); step();
    drv(1, 5, 7, 0, 0, 2'b00, 0, 0, 0, 0); step();
    for (int i = 0; i < 12; i++) begin
      drv(1, IW'(i), IW'(i + 20), 0, 0, 2'b00, 0, 0, 0, 0); step();
    end

    for (int i = 0; i < 200; i++) rnd_step();

    repeat (3) @(posedge CLK);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
